// File: rtl/image_write_pair_pkg.sv
// ============================================================================
// Module : image_write_pair_pkg
// Brief  : Shared FSM state type, pixel width and byte-pack helpers for the
//          image_write_pair frame store.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package image_write_pair_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [RGB_W-1:0] pack_rgb(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
        return {r, g, b};
    endfunction

    function automatic logic [15:0] rgb_byte_sum(input logic [RGB_W-1:0] p);
        return 16'(p[23:16]) + 16'(p[15:8]) + 16'(p[7:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/image_write_pair_pixel_bank.sv
// ============================================================================
// Module : image_write_pair_pixel_bank
// Brief  : Simple dual-port RAM, one write port and one registered read port.
//          Read-during-write of the same address returns the old contents.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module image_write_pair_pixel_bank #(
    parameter int DEPTH = 2,
    parameter int ABW   = 1,
    parameter int DW    = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we_i,
    input  logic [ABW-1:0] waddr_i,
    input  logic [DW-1:0]  wdata_i,
    input  logic [ABW-1:0] raddr_i,
    output logic [DW-1:0]  rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage is intentionally left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/image_write_pair.sv
// ============================================================================
// Module : image_write_pair
// Brief  : Captures a two-pixels-per-clock RGB stream into a bottom-up frame
//          store (even/odd column banks). Optional running byte checksum
//          enabled by IMAGE_WRITE_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module image_write_pair
    import image_write_pair_pkg::*;
#(
    parameter  int WIDTH  = 640,
    parameter  int HEIGHT = 480,
    localparam int AW     = $clog2(WIDTH * HEIGHT)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             VSYNC,
    input  logic             HSYNC,
    input  logic [7:0]       DATA_R0,
    input  logic [7:0]       DATA_G0,
    input  logic [7:0]       DATA_B0,
    input  logic [7:0]       DATA_R1,
    input  logic [7:0]       DATA_G1,
    input  logic [7:0]       DATA_B1,
    input  logic [AW-1:0]    rd_addr,
    output logic [RGB_W-1:0] rd_data,
    output logic             busy,
    output logic             write_done,
    output logic             frame_err,
    output logic [15:0]      checksum
);

    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BAW   = (AW > 1) ? AW - 1 : 1;
    localparam int DEPTH = (WIDTH * HEIGHT) / 2;

    localparam logic [AW-1:0] TOP_BASE = AW'((HEIGHT - 1) * WIDTH);
    localparam logic [AW-1:0] ROW_STEP = AW'(WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 2);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] base_q, base_d;
    logic          frame_err_q, frame_err_d;
    logic          rd_sel_q;

    logic          frame_start;
    logic          accept;
    logic [CW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    logic [AW-1:0] base_eff;
    logic [AW-1:0] wr_addr;
    logic [RGB_W-1:0] pix0, pix1;
    logic [RGB_W-1:0] rd_even, rd_odd;

    // A VSYNC in IDLE or ACTIVE (re)starts the frame; a same-cycle pair lands at row 0 / col 0.
    assign frame_start = VSYNC && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
    assign accept      = HSYNC && ((state_q == ST_ACTIVE) || frame_start);
    assign col_eff     = frame_start ? '0 : col_q;
    assign row_eff     = frame_start ? '0 : row_q;
    assign base_eff    = frame_start ? TOP_BASE : base_q;
    assign wr_addr     = base_eff + AW'(col_eff);

    assign pix0 = pack_rgb(DATA_R0, DATA_G0, DATA_B0);
    assign pix1 = pack_rgb(DATA_R1, DATA_G1, DATA_B1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_eff;
        row_d       = row_eff;
        base_d      = base_eff;
        frame_err_d = frame_err_q;

        case (state_q)
            ST_IDLE:   if (VSYNC) state_d = ST_ACTIVE;
            ST_ACTIVE: if (VSYNC) frame_err_d = 1'b1;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (col_eff == LAST_COL) begin
                col_d = '0;
                if (row_eff == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    row_d  = row_eff + 1'b1;
                    base_d = base_eff - ROW_STEP;
                end
            end else begin
                col_d = col_eff + CW'(2);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            base_q      <= TOP_BASE;
            frame_err_q <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            base_q      <= base_d;
            frame_err_q <= frame_err_d;
            rd_sel_q    <= rd_addr[0];
        end
    end

`ifdef IMAGE_WRITE_CHECKSUM_EN
    logic [15:0] cs_q, cs_d;
    logic [15:0] pair_sum;

    assign pair_sum = rgb_byte_sum(pix0) + rgb_byte_sum(pix1);

    always_comb begin
        cs_d = cs_q;
        if (frame_start) begin
            cs_d = accept ? pair_sum : 16'h0000;
        end else if (accept) begin
            cs_d = cs_q + pair_sum;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cs_q <= 16'h0000;
        end else begin
            cs_q <= cs_d;
        end
    end

    assign checksum = cs_q;
`else
    assign checksum = 16'h0000;
`endif

    image_write_pair_pixel_bank #(
        .DEPTH (DEPTH),
        .ABW   (BAW),
        .DW    (RGB_W)
    ) u_bank_even (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .we_i    (accept),
        .waddr_i (BAW'(wr_addr >> 1)),
        .wdata_i (pix0),
        .raddr_i (BAW'(rd_addr >> 1)),
        .rdata_o (rd_even)
    );

    image_write_pair_pixel_bank #(
        .DEPTH (DEPTH),
        .ABW   (BAW),
        .DW    (RGB_W)
    ) u_bank_odd (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .we_i    (accept),
        .waddr_i (BAW'(wr_addr >> 1)),
        .wdata_i (pix1),
        .raddr_i (BAW'(rd_addr >> 1)),
        .rdata_o (rd_odd)
    );

    assign rd_data    = rd_sel_q ? rd_odd : rd_even;
    assign busy       = (state_q == ST_ACTIVE);
    assign write_done = (state_q == ST_DONE);
    assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_image_write_pair.sv
// ============================================================================
// Module : tb_image_write_pair
// Brief  : Self-checking bench for image_write_pair at WIDTH=4, HEIGHT=2 with
//          a read-back scoreboard fed from a bench-side frame model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_image_write_pair;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = $clog2(W * H);
`ifdef IMAGE_WRITE_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          VSYNC, HSYNC;
    logic [7:0]    DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_data;
    logic          busy, write_done, frame_err;
    logic [15:0]   checksum;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [23:0] model [W*H];
    logic [23:0] exp_q [$];
    logic [15:0] exp_cs;

    image_write_pair #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .VSYNC      (VSYNC),
        .HSYNC      (HSYNC),
        .DATA_R0    (DATA_R0),
        .DATA_G0    (DATA_G0),
        .DATA_B0    (DATA_B0),
        .DATA_R1    (DATA_R1),
        .DATA_G1    (DATA_G1),
        .DATA_B1    (DATA_B1),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .write_done (write_done),
        .frame_err  (frame_err),
        .checksum   (checksum)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) if (write_done === 1'b1) done_cnt++;

    function automatic logic [23:0] pix(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {b, b ^ 8'h55, b + 8'h80};
    endfunction

    function automatic logic [15:0] bsum(input logic [23:0] p);
        return 16'(p[23:16]) + 16'(p[15:8]) + 16'(p[7:0]);
    endfunction

    task automatic drive(input logic vs, input logic hs, input logic [23:0] p0, input logic [23:0] p1);
        VSYNC = vs;
        HSYNC = hs;
        {DATA_R0, DATA_G0, DATA_B0} = p0;
        {DATA_R1, DATA_G1, DATA_B1} = p1;
        @(posedge HCLK);
        #1;
        VSYNC = 1'b0;
        HSYNC = 1'b0;
    endtask

    // Model write for pair k of a frame: bottom-up row order.
    task automatic model_pair(input int k, input logic [23:0] p0, input logic [23:0] p1);
        int r, c, a;
        r = (k * 2) / W;
        c = (k * 2) % W;
        a = (H - 1 - r) * W + c;
        model[a]     = p0;
        model[a + 1] = p1;
        exp_cs       = exp_cs + bsum(p0) + bsum(p1);
    endtask

    task automatic check_flags(input string name, input logic eb, input logic ed);
        n_tests++;
        if (busy !== eb || write_done !== ed) begin
            n_fail++;
            $display("FAIL %s: busy=%b write_done=%b, expected busy=%b write_done=%b",
                     name, busy, write_done, eb, ed);
        end
    endtask

    task automatic readback(input string name);
        logic [23:0] e;
        for (int a = 0; a < W * H; a++) begin
            rd_addr = AW'(a);
            exp_q.push_back(model[a]);
            @(posedge HCLK);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if (rd_data !== e) begin
                n_fail++;
                $display("FAIL %s addr %0d: rd_data=%h expected %h", name, a, rd_data, e);
            end
        end
    endtask

    task automatic send_frame(input string name, input int base, input int gap, input bit vs_first);
        logic [23:0] p0, p1;
        exp_cs = 16'h0000;
        if (!vs_first) begin
            drive(1'b1, 1'b0, '0, '0);
            check_flags({name, " start"}, 1'b1, 1'b0);
        end
        for (int k = 0; k < (W * H) / 2; k++) begin
            p0 = pix(base + 2 * k);
            p1 = pix(base + 2 * k + 1);
            drive(vs_first && (k == 0), 1'b1, p0, p1);
            model_pair(k, p0, p1);
            if (k < (W * H) / 2 - 1) begin
                check_flags({name, " mid"}, 1'b1, 1'b0);
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, 1'b0, '0, '0);
                    check_flags({name, " gap"}, 1'b1, 1'b0);
                end
            end
        end
        check_flags({name, " done"}, 1'b0, 1'b1);
        n_tests++;
        if (checksum !== (CS_EN ? exp_cs : 16'h0000)) begin
            n_fail++;
            $display("FAIL %s checksum: got %h expected %h", name, checksum, CS_EN ? exp_cs : 16'h0000);
        end
        drive(1'b0, 1'b0, '0, '0);
        check_flags({name, " after"}, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (busy !== 1'b0 || write_done !== 1'b0 || frame_err !== 1'b0 ||
            rd_data !== 24'h0 || checksum !== 16'h0) begin
            n_fail++;
            $display("FAIL %s: busy=%b done=%b err=%b rd=%h cs=%h expected all zero",
                     name, busy, write_done, frame_err, rd_data, checksum);
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check_reset_outputs("reset_initial");
        HRESETn = 1'b1;
        drive(1'b1, 1'b1, pix(1), pix(2));
        drive(1'b0, 1'b1, pix(3), pix(4));
        check_flags("reset_prebusy", 1'b1, 1'b0);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("reset_midframe");
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        // A fresh frame after reset must start at row 0 / col 0.
        for (int a = 0; a < W * H; a++) model[a] = 24'hx;
        send_frame("reset_clean", 0, 0, 1'b0);
        readback("reset_clean_rd");
    endtask

    task automatic test_frame();
        int d0;
        d0 = done_cnt;
        send_frame("frame", 0, 0, 1'b0);
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d expected 1", done_cnt - d0);
        end
        readback("frame_rd");
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_clean: got %b expected 0", frame_err);
        end
    endtask

    task automatic test_hsync_gaps();
        send_frame("gaps", 100, 3, 1'b0);
        readback("gaps_rd");
    endtask

    task automatic test_vsync_restart();
        int d0;
        d0 = done_cnt;
        exp_cs = 16'h0000;
        drive(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, pix(50 + 2 * k), pix(51 + 2 * k));
            model_pair(k, pix(50 + 2 * k), pix(51 + 2 * k));
        end
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_err_before: got %b expected 0", frame_err);
        end
        send_frame("restart", 200, 0, 1'b1);
        n_tests++;
        if (frame_err !== 1'b1 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL restart_err: frame_err=%b done_pulses=%0d expected 1 and 1",
                     frame_err, done_cnt - d0);
        end
        readback("restart_rd");
    endtask

    task automatic test_hsync_idle();
        HRESETn = 1'b0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
        end
        check_flags("idle_hsync", 1'b0, 1'b0);
        n_tests++;
        if (checksum !== 16'h0000 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_checksum: cs=%h err=%b expected 0000 and 0", checksum, frame_err);
        end
        readback("idle_rd");
    endtask

    task automatic test_checksum();
        logic [23:0] p, old4;
        logic [15:0] want;
        p = 24'h808080;
        old4 = model[4];
        want = CS_EN ? 16'h0C00 : 16'h0000;
        rd_addr = AW'(4);
        drive(1'b1, 1'b1, p, p);
        n_tests++;
        if (rd_data !== old4) begin
            n_fail++;
            $display("FAIL read_during_write: rd_data=%h expected old %h", rd_data, old4);
        end
        exp_cs = 16'h0000;
        model_pair(0, p, p);
        for (int k = 1; k < (W * H) / 2; k++) begin
            drive(1'b0, 1'b1, p, p);
            model_pair(k, p, p);
        end
        check_flags("cs_done", 1'b0, 1'b1);
        n_tests++;
        if (checksum !== want) begin
            n_fail++;
            $display("FAIL cs_value: got %h expected %h", checksum, want);
        end
        drive(1'b0, 1'b1, 24'h010101, 24'h010101);
        drive(1'b0, 1'b0, '0, '0);
        n_tests++;
        if (checksum !== want) begin
            n_fail++;
            $display("FAIL cs_frozen: got %h expected %h", checksum, want);
        end
        readback("cs_rd");
    endtask

    initial begin
        HRESETn = 1'b0;
        VSYNC   = 1'b0;
        HSYNC   = 1'b0;
        rd_addr = '0;
        {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = '0;
        exp_cs  = 16'h0000;
        test_reset();
        test_frame();
        test_hsync_gaps();
        test_vsync_restart();
        test_hsync_idle();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
